div_unit: RTL
=============

# div_unit

Multi-cycle RV32M divider for DIV, DIVU, REM and REMU, sitting in the execute stage directly upstream of the register file. It accepts one operation at a time from the decode/execute pipeline. It computes the result with a radix-2 restoring algorithm, one quotient bit per cycle. On completion it drives the register-file write port (`reg_waddr`/`reg_wdata`/`reg_wen`) for exactly one cycle.

## Interface
- `XLEN`, default 32: operand and result width. Only 32 is supported.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_i`  in  1  request strobe; sampled only in IDLE.
- `op_i`  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
- `dividend_i`  in  32  rs1 value.
- `divisor_i`  in  32  rs2 value.
- `rd_i`  in  5  destination register.
- `kill_i`  in  1  pipeline flush; abandons the in-flight operation.
- `busy_o`  out  1  high while an operation is held (CALC or DONE); the stall request to the pipeline.
- `reg_waddr_o`  out  5  writeback address to the register file.
- `reg_wdata_o`  out  32  writeback data to the register file.
- `reg_wen_o`  out  1  writeback enable, one-cycle pulse.

## Operation
- **States**
  - IDLE: waits for `start_i`.
  - CALC: runs the 32 iterations.
  - DONE: presents the result for one cycle, then returns to IDLE.
- **IDLE → CALC** when `start_i`=1 and `kill_i`=0.
  - Latch `op_i`, `rd_i` and the operand magnitudes.
  - Signed ops (DIV/REM) use absolute values.
  - Record `neg_q` = sign(dividend) XOR sign(divisor).
  - Record `neg_r` = sign(dividend).
  - Clear the iteration counter to 0.
- **CALC iteration** (one per edge): remainder `{r,q}` shifts left 1; the 33-bit trial `r − divisor` is computed.
  - If the trial is non-negative: `r` takes the trial value and the q LSB is 1.
  - Otherwise the q LSB is 0.
- **CALC → DONE** after iteration 32, i.e. counter value 31.
- **Result selection** in DONE:
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
  - Signed results are negated per `neg_q`/`neg_r`.
- **Special cases** (fixed results, applied in DONE):
  - Divide by zero: DIV and DIVU return 0xFFFFFFFF; REM and REMU return the original dividend.
  - Signed overflow (DIV of 0x80000000 by 0xFFFFFFFF): returns 0x80000000. The matching REM returns 0.
- **DONE → IDLE** unconditionally on the next edge.
- **`start_i` handling**: ignored in CALC and DONE; no queuing.
- **`kill_i` handling**: in CALC or DONE, the next state is IDLE and `reg_wen_o` stays 0 (kill in DONE suppresses the pulse). `kill_i` in IDLE overrides a same-cycle `start_i`.
- **`rd_i`=0**: the operation runs normally but `reg_wen_o` stays 0.
- **Reset**: `rst` forces IDLE from any state, including mid-CALC, and the result is discarded.

## Timing
- **Reset values**: state IDLE, `busy_o`=0, `reg_wen_o`=0, `reg_waddr_o`=0, `reg_wdata_o`=0.
- **Latency** (cycle k lies between edge k and edge k+1):
  - Start sampled at edge 0, with `busy_o`=1 from cycle 0.
  - Iterations run on edges 1..32.
  - DONE is registered at edge 33: `reg_wen_o`=1 in cycle 33 only, and `busy_o`=1 through cycle 33.
  - IDLE at edge 34, so the earliest next start is sampled at edge 34.
- **Throughput**: one operation per 34 cycles.
- **Output registering**: `reg_waddr_o`/`reg_wdata_o` are registered and valid whenever `reg_wen_o`=1. They hold their last value otherwise.
- **Operand latching**: operands are captured at edge 0; later changes on the inputs are ignored.
- **Same-cycle `rst` and `kill_i`**: `rst` wins; the outcome is identical.

## Configuration
- `DIV_FAST_SPECIAL_EN`
  - Defined: divide-by-zero and signed-overflow operations go IDLE → DONE directly at edge 0+1, skipping CALC. `reg_wen_o` is asserted in cycle 1 and `busy_o` in cycle 0–1.
  - Undefined: these cases take the full 34-cycle path.
  - Result values are identical in both builds; only latency differs.

## Test plan
- **DIVU**: 100 / 7, rd=5 → `reg_wen_o` high only in cycle 33, `reg_waddr_o`=5, `reg_wdata_o`=14. REMU with the same operands → 2.
- **DIV and REM, signed**: DIV −100 (0xFFFFFF9C) / 7 → 0xFFFFFFF2 (−14). REM → 0xFFFFFFFE (−2).
- **Signed special cases**:
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
  - DIV 55 / 0 → 0xFFFFFFFF; REM 55 / 0 → 55.
  - Check the cycle of the `reg_wen_o` pulse: 1 with `DIV_FAST_SPECIAL_EN`, 33 without.
- **Kill**: assert `kill_i` in cycle 10 of a DIVU → no `reg_wen_o` pulse. `busy_o`=0 from cycle 11, and a new start accepted in cycle 11 completes correctly.
- **Ignored and suppressed requests**:
  - A `start_i` pulse with different operands in cycle 5 mid-operation → ignored; the original result is written.
  - An operation with rd=0 → `busy_o` sequence unchanged, `reg_wen_o` never asserted.
- **Reset mid-operation**: assert `rst` in cycle 20 → all outputs at reset values in cycle 21 and no write-back pulse. A subsequent DIVU of 0xFFFFFFFF / 1 returns 0xFFFFFFFF.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: radix-2 restoring RV32M divider (DIV/DIVU/REM/REMU), optional DIV_FAST_SPECIAL_EN shortcut for special cases
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic [4:0]      rd_i,
    input  logic            kill_i,
    output logic            busy_o,
    output logic [4:0]      reg_waddr_o,
    output logic [XLEN-1:0] reg_wdata_o,
    output logic            reg_wen_o
);
`ifdef DIV_FAST_SPECIAL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t          state;
    logic [1:0]      op;
    logic [4:0]      rd;
    logic            neg_q, neg_r, dz, ovf, wen;
    logic [XLEN-1:0] dvd, dsr, r, q;
    logic [5:0]      cnt;
    logic            sgn_in, dz_in, ovf_in;
    logic [XLEN-1:0] a_mag, b_mag, quo, rem, res;
    logic [XLEN:0]   trial;
    assign sgn_in = ~op_i[0];
    assign a_mag  = sgn_in && dividend_i[XLEN-1] ? -dividend_i : dividend_i;
    assign b_mag  = sgn_in && divisor_i[XLEN-1] ? -divisor_i : divisor_i;
    assign dz_in  = divisor_i == '0;
    assign ovf_in = sgn_in && dividend_i == MIN_NEG && divisor_i == '1;
    assign trial  = {r, q[XLEN-1]} - {1'b0, dsr};
    assign quo    = neg_q ? -q : q;
    assign rem    = neg_r ? -r : r;
    assign res    = dz ? (op[1] ? dvd : '1) : ovf ? (op[1] ? '0 : MIN_NEG) : op[1] ? rem : quo;
    assign busy_o = state != IDLE;
    // a flush in the DONE cycle must still suppress the already-registered write
    assign reg_wen_o = wen & ~kill_i;
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wen         <= 1'b0;
            reg_waddr_o <= '0;
            reg_wdata_o <= '0;
        end else begin
            wen <= 1'b0;
            case (state)
                IDLE: if (start_i && !kill_i) begin
                    state <= CALC;
                    op    <= op_i;
                    rd    <= rd_i;
                    dvd   <= dividend_i;
                    dsr   <= b_mag;
                    q     <= a_mag;
                    r     <= '0;
                    neg_q <= sgn_in & (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
                    neg_r <= sgn_in & dividend_i[XLEN-1];
                    dz    <= dz_in;
                    ovf   <= ovf_in;
                    // special cases jump straight to the result cycle when the shortcut is built in
                    cnt   <= FAST && (dz_in || ovf_in) ? 6'd32 : 6'd0;
                end
                CALC: if (kill_i) begin
                    state <= IDLE;
                end else if (cnt[5]) begin
                    state <= DONE;
                    wen   <= rd != 5'd0;
                    if (rd != 5'd0) begin
                        reg_waddr_o <= rd;
                        reg_wdata_o <= res;
                    end
                end else begin
                    cnt <= cnt + 6'd1;
                    q   <= {q[XLEN-2:0], ~trial[XLEN]};
                    r   <= trial[XLEN] ? {r[XLEN-2:0], q[XLEN-1]} : trial[XLEN-1:0];
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
